lcd_hd44780_driver: RTL

//  Consumer end of the CPU LCD register: takes the 32-bit LCD word the LSU drives to the IO map and performs

---
 rtl/lcd_hd44780_driver.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/lcd_hd44780_driver.sv
// Drives timed HD44780 write cycles from the CPU LCD register.
// Software toggles REQ once per command or character. RW stays low because the block only writes.
module lcd_hd44780_driver #(
    parameter int POR_CYC       = 750000,
    parameter int SETUP_CYC     = 2,
    parameter int EN_CYC        = 12,
    parameter int HOLD_CYC      = 2,
    parameter int EXEC_CYC      = 2000,
    parameter int LONG_EXEC_CYC = 82000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_lcd_reg,
    output logic        o_lcd_busy,
    output logic        o_lcd_ack_tgl,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(max2(POR_CYC, SETUP_CYC), max2(EN_CYC, HOLD_CYC)),
                                  max2(EXEC_CYC, LONG_EXEC_CYC));
    localparam int CW = $clog2(MAX_CYC + 1);

    localparam logic [2:0] S_POR   = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_EN    = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_EXEC  = 3'd5;

    // The counter is loaded with (cycles - 1) when a state is entered. The state exits when the counter reaches zero.
    localparam logic [CW-1:0] POR_LD   = CW'(POR_CYC - 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LD    = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] EXEC_LD  = CW'(EXEC_CYC - 1);
    localparam logic [CW-1:0] LONG_LD  = CW'(LONG_EXEC_CYC - 1);

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_seen_tgl;
    logic          r_long;
    logic          r_busy;
    logic          r_ack_tgl;
    logic          r_on;
    logic          r_en;
    logic          r_rs;
    logic [7:0]    r_data;

    logic w_pend;
    logic w_long_cmd;
    logic w_cnt_done;

    assign w_pend     = (i_lcd_reg[12] != r_seen_tgl);
    assign w_long_cmd = !i_lcd_reg[9] &&
                        (i_lcd_reg[7:0] == 8'h01 || i_lcd_reg[7:0] == 8'h02 ||
                         i_lcd_reg[7:0] == 8'h03);
    assign w_cnt_done = (r_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_POR;
            r_cnt      <= POR_LD;
            r_seen_tgl <= 1'b0;
            r_long     <= 1'b0;
            r_busy     <= 1'b1;
            r_ack_tgl  <= 1'b0;
            r_on       <= 1'b0;
            r_en       <= 1'b0;
            r_rs       <= 1'b0;
            r_data     <= 8'h00;
        end else begin
            r_on <= i_lcd_reg[31];
            if (!w_cnt_done) begin
                r_cnt <= r_cnt - CW'(1);
            end
            case (r_state)
                S_POR: begin
                    if (w_cnt_done) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (w_pend) begin
                        r_rs       <= i_lcd_reg[9];
                        r_data     <= i_lcd_reg[7:0];
                        r_seen_tgl <= i_lcd_reg[12];
                        r_long     <= w_long_cmd;
                        r_cnt      <= SETUP_LD;
                        r_busy     <= 1'b1;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_cnt_done) begin
                        r_en    <= 1'b1;
                        r_cnt   <= EN_LD;
                        r_state <= S_EN;
                    end
                end
                S_EN: begin
                    if (w_cnt_done) begin
                        r_en    <= 1'b0;
                        r_cnt   <= HOLD_LD;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_cnt_done) begin
                        r_cnt   <= r_long ? LONG_LD : EXEC_LD;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_cnt_done) begin
                        r_busy    <= 1'b0;
                        r_ack_tgl <= ~r_ack_tgl;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_lcd_busy    = r_busy;
    assign o_lcd_ack_tgl = r_ack_tgl;
    assign o_lcd_on      = r_on;
    assign o_lcd_en      = r_en;
    assign o_lcd_rs      = r_rs;
    assign o_lcd_rw      = 1'b0;
    assign o_lcd_data    = r_data;
endmodule
